// File: rtl/trap_ctrl.sv
// Trap sequencer: flushes the pipeline, writes mepc/mcause/mstatus in order,
// then issues a one-cycle fetch redirect to the trap vector or to mepc.
module trap_ctrl #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_valid_i,
    input  logic [3:0]      exc_code_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic            mret_i,
    input  logic            irq_timer_i,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            csr_we_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            flush_o,
    output logic            stall_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o
);

    localparam int unsigned EPCW = XLEN - 2;
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_REDIRECT
    } state_t;

    typedef enum logic [1:0] {
        K_EXC,
        K_IRQ,
        K_MRET
    } kind_t;

    state_t          state_q, state_d;
    kind_t           kind_q, kind_d;
    logic [EPCW-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;

    logic            csr_we_d;
    logic [11:0]     csr_addr_d;
    logic [XLEN-1:0] csr_wdata_d;
    logic            flush_d;
    logic            stall_d;
    logic            redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_d;
    logic            busy_d;

    logic            irq_pending;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] mstatus_next;

    // Low pc bits are always forced to zero and only MTIE is used from mie.
    logic unused_bits;
    assign unused_bits = ^{exc_pc_i[1:0], irq_pc_i[1:0], mepc_i[1:0],
                           mie_i[XLEN-1:8], mie_i[6:0]};

    assign irq_pending = irq_timer_i & mstatus_i[3] & mie_i[7];
    assign trap_base   = {mtvec_i[XLEN-1:2], 2'b00};

    // mstatus update for trap entry or mret
    always_comb begin
        mstatus_next        = mstatus_i;
        mstatus_next[12:11] = 2'b11;
        if (kind_q == K_MRET) begin
            mstatus_next[3] = mstatus_i[7];
            mstatus_next[7] = 1'b1;
        end else begin
            mstatus_next[7] = mstatus_i[3];
            mstatus_next[3] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_EXC;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    // Next state, event latch, and the outputs belonging to the next state
    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        epc_d            = epc_q;
        cause_d          = cause_q;
        csr_we_d         = 1'b0;
        csr_addr_d       = '0;
        csr_wdata_d      = '0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (exc_valid_i) begin
                    state_d = S_FLUSH;
                    kind_d  = K_EXC;
                    epc_d   = exc_pc_i[XLEN-1:2];
                    cause_d = XLEN'(exc_code_i);
                end else if (mret_i) begin
                    state_d = S_FLUSH;
                    kind_d  = K_MRET;
                end else if (irq_pending) begin
                    state_d = S_FLUSH;
                    kind_d  = K_IRQ;
                    epc_d   = irq_pc_i[XLEN-1:2];
                    cause_d = {1'b1, (XLEN-1)'(7)};
                end
            end
            S_FLUSH:     state_d = (kind_q == K_MRET) ? S_W_MSTATUS : S_W_MEPC;
            S_W_MEPC:    state_d = S_W_MCAUSE;
            S_W_MCAUSE:  state_d = S_W_MSTATUS;
            S_W_MSTATUS: state_d = S_REDIRECT;
            S_REDIRECT:  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        case (state_d)
            S_FLUSH: flush_d = 1'b1;
            S_W_MEPC: begin
                csr_we_d    = 1'b1;
                csr_addr_d  = ADDR_MEPC;
                csr_wdata_d = {epc_q, 2'b00};
            end
            S_W_MCAUSE: begin
                csr_we_d    = 1'b1;
                csr_addr_d  = ADDR_MCAUSE;
                csr_wdata_d = cause_q;
            end
            S_W_MSTATUS: begin
                csr_we_d    = 1'b1;
                csr_addr_d  = ADDR_MSTATUS;
                csr_wdata_d = mstatus_next;
            end
            S_REDIRECT: begin
                redirect_valid_d = 1'b1;
                if (kind_q == K_MRET)
                    redirect_pc_d = {mepc_i[XLEN-1:2], 2'b00};
                else if (kind_q == K_IRQ && mtvec_i[1:0] == 2'b01)
                    redirect_pc_d = trap_base + XLEN'(28);
                else
                    redirect_pc_d = trap_base;
            end
            default: ;
        endcase

        stall_d = (state_d != S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_we_o         <= 1'b0;
            csr_addr_o       <= '0;
            csr_wdata_o      <= '0;
            flush_o          <= 1'b0;
            stall_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            busy_o           <= 1'b0;
        end else begin
            csr_we_o         <= csr_we_d;
            csr_addr_o       <= csr_addr_d;
            csr_wdata_o      <= csr_wdata_d;
            flush_o          <= flush_d;
            stall_o          <= stall_d;
            redirect_valid_o <= redirect_valid_d;
            redirect_pc_o    <= redirect_pc_d;
            busy_o           <= busy_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: cycle-by-cycle output checks per scenario.
module tb_trap_ctrl;

    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic            we;
        logic [11:0]     addr;
        logic [XLEN-1:0] wdata;
        logic            flush;
        logic            stall;
        logic            redir;
        logic [XLEN-1:0] rpc;
        logic            busy;
    } outs_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            exc_valid;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] exc_pc;
    logic            mret;
    logic            irq_timer;
    logic [XLEN-1:0] irq_pc;
    logic [XLEN-1:0] mstatus, mie, mtvec, mepc;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            flush, stall, redirect_valid, busy;
    logic [XLEN-1:0] redirect_pc;

    int pass_cnt  = 0;
    int total_cnt = 0;

    trap_ctrl #(.XLEN(XLEN)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .exc_valid_i      (exc_valid),
        .exc_code_i       (exc_code),
        .exc_pc_i         (exc_pc),
        .mret_i           (mret),
        .irq_timer_i      (irq_timer),
        .irq_pc_i         (irq_pc),
        .mstatus_i        (mstatus),
        .mie_i            (mie),
        .mtvec_i          (mtvec),
        .mepc_i           (mepc),
        .csr_we_o         (csr_we),
        .csr_addr_o       (csr_addr),
        .csr_wdata_o      (csr_wdata),
        .flush_o          (flush),
        .stall_o          (stall),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    function automatic outs_t cur();
        return {csr_we, csr_addr, csr_wdata, flush, stall, redirect_valid, redirect_pc, busy};
    endfunction

    function automatic outs_t o_idle();
        return '0;
    endfunction

    function automatic outs_t o_flush();
        outs_t o = '0;
        o.flush = 1'b1; o.stall = 1'b1; o.busy = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_wr(input logic [11:0] a, input logic [XLEN-1:0] d);
        outs_t o = '0;
        o.we = 1'b1; o.addr = a; o.wdata = d; o.stall = 1'b1; o.busy = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_redir(input logic [XLEN-1:0] pc);
        outs_t o = '0;
        o.redir = 1'b1; o.rpc = pc; o.stall = 1'b1; o.busy = 1'b1;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; exc_valid = 0; exc_code = 0; exc_pc = 0; mret = 0;
        irq_timer = 0; irq_pc = 0; mstatus = 0; mie = 0; mtvec = 0; mepc = 0;
        #12;
        total_cnt++;
        if (cur() !== o_idle()) $display("FAIL reset got %h exp %h", cur(), o_idle());
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        step();
        total_cnt++;
        if (cur() !== o_idle()) $display("FAIL reset_release got %h exp %h", cur(), o_idle());
        else pass_cnt++;
    endtask

    task automatic test_ecall();
        outs_t exp [6];
        exp[0] = o_flush();
        exp[1] = o_wr(12'h341, 64'h8000_0104);
        exp[2] = o_wr(12'h342, 64'd11);
        exp[3] = o_wr(12'h300, 64'h1880);
        exp[4] = o_redir(64'h8000_1000);
        exp[5] = o_idle();
        mstatus = 64'h8; mtvec = 64'h8000_1000; exc_code = 4'd11; exc_pc = 64'h8000_0104;
        exc_valid = 1'b1;
        step();
        exc_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (cur() !== exp[i]) $display("FAIL ecall cyc%0d got %h exp %h", i + 1, cur(), exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_mret();
        outs_t exp [4];
        exp[0] = o_flush();
        exp[1] = o_wr(12'h300, 64'h1888);
        exp[2] = o_redir(64'h8000_0108);
        exp[3] = o_idle();
        mstatus = 64'h1880; mepc = 64'h8000_0108;
        mret = 1'b1;
        step();
        mret = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (cur() !== exp[i]) $display("FAIL mret cyc%0d got %h exp %h", i + 1, cur(), exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_irq_vectored();
        outs_t exp [6];
        exp[0] = o_flush();
        exp[1] = o_wr(12'h341, 64'h8000_0200);
        exp[2] = o_wr(12'h342, 64'h8000_0000_0000_0007);
        exp[3] = o_wr(12'h300, 64'h1880);
        exp[4] = o_redir(64'h8000_101C);
        exp[5] = o_idle();
        mstatus = 64'h8; mie = 64'h80; mtvec = 64'h8000_1001; irq_pc = 64'h8000_0200;
        irq_timer = 1'b1;
        step();
        irq_timer = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (cur() !== exp[i]) $display("FAIL irq_vec cyc%0d got %h exp %h", i + 1, cur(), exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_priority();
        outs_t exp_a [8];
        outs_t exp_b [10];
        exp_a[0] = o_flush();
        exp_a[1] = o_wr(12'h341, 64'h8000_0300);
        exp_a[2] = o_wr(12'h342, 64'd2);
        exp_a[3] = o_wr(12'h300, 64'h1880);
        exp_a[4] = o_redir(64'h8000_2000);
        exp_a[5] = o_idle();
        exp_a[6] = o_idle();
        exp_a[7] = o_idle();
        exp_b[0] = o_flush();
        exp_b[1] = o_wr(12'h300, 64'h1888);
        exp_b[2] = o_redir(64'h8000_0300);
        exp_b[3] = o_idle();
        exp_b[4] = o_flush();
        exp_b[5] = o_wr(12'h341, 64'h8000_0400);
        exp_b[6] = o_wr(12'h342, 64'h8000_0000_0000_0007);
        exp_b[7] = o_wr(12'h300, 64'h1880);
        exp_b[8] = o_redir(64'h8000_2000);
        exp_b[9] = o_idle();
        mstatus = 64'h8; mie = 64'h80; mtvec = 64'h8000_2000;
        exc_code = 4'd2; exc_pc = 64'h8000_0300; irq_pc = 64'h8000_0400;
        exc_valid = 1'b1; irq_timer = 1'b1;
        step();
        exc_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (cur() !== exp_a[i]) $display("FAIL prio_exc cyc%0d got %h exp %h", i + 1, cur(), exp_a[i]);
            else pass_cnt++;
            // CSR file commits the trap-entry writes
            if (i == 3) begin mstatus = 64'h1880; mepc = 64'h8000_0300; end
        end
        mret = 1'b1;
        step();
        mret = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (cur() !== exp_b[i]) $display("FAIL prio_mret_irq cyc%0d got %h exp %h", i + 1, cur(), exp_b[i]);
            else pass_cnt++;
            if (i == 1) mstatus = 64'h1888;
            if (i == 4) irq_timer = 1'b0;
            if (i == 7) mstatus = 64'h1880;
        end
    endtask

    task automatic test_masked_irq();
        mstatus = 64'h0; mie = 64'h80; mtvec = 64'h8000_1000;
        irq_timer = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total_cnt++;
            if (busy !== 1'b0 || csr_we !== 1'b0 || flush !== 1'b0)
                $display("FAIL masked_irq cyc%0d got busy=%b we=%b flush=%b exp 0 0 0", i, busy, csr_we, flush);
            else pass_cnt++;
        end
        irq_timer = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        outs_t exp [6];
        exp[0] = o_flush();
        exp[1] = o_wr(12'h341, 64'h8000_0104);
        exp[2] = o_wr(12'h342, 64'd11);
        exp[3] = o_wr(12'h300, 64'h1880);
        exp[4] = o_redir(64'h8000_1000);
        exp[5] = o_idle();
        mstatus = 64'h8; mtvec = 64'h8000_1000; exc_code = 4'd11; exc_pc = 64'h8000_0104;
        exc_valid = 1'b1;
        step();
        exc_valid = 1'b0;
        step();
        step();
        total_cnt++;
        if (cur() !== exp[2]) $display("FAIL rst_mid_pre got %h exp %h", cur(), exp[2]);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (cur() !== o_idle()) $display("FAIL rst_mid_async got %h exp %h", cur(), o_idle());
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        step();
        total_cnt++;
        if (cur() !== o_idle()) $display("FAIL rst_mid_idle got %h exp %h", cur(), o_idle());
        else pass_cnt++;
        exc_valid = 1'b1;
        step();
        exc_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (cur() !== exp[i]) $display("FAIL rst_mid_ecall cyc%0d got %h exp %h", i + 1, cur(), exp[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_irq_vectored();
        test_priority();
        test_masked_irq();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
